// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon memory-game sequencer: LFSR pattern, timed playback, press checking.
// Define SIMON_SEQ_TIMEOUT_EN to lose the game when no press arrives within TIMEOUT_MS in WAIT_IN.
module simon_sequencer #(
  parameter int MAX_LEN    = 32,
  parameter int ON_MS      = 300,
  parameter int GAP_MS     = 100,
  parameter int TIMEOUT_MS = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  input  logic        start,
  input  logic [3:0]  btn,
  output logic [3:0]  led,
  output logic        sound_en,
  output logic [1:0]  tone,
  output logic [5:0]  level,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  localparam int PAUSE_MS = 500;
  localparam int LEN_W    = 6;
  localparam int IDX_W    = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam int MS_A     = (ON_MS > GAP_MS) ? ON_MS : GAP_MS;
  localparam int MS_B     = (MS_A > PAUSE_MS) ? MS_A : PAUSE_MS;
  localparam int MS_MAX   = (MS_B > TIMEOUT_MS) ? MS_B : TIMEOUT_MS;
  localparam int MS_W     = $clog2(MS_MAX + 1);

  localparam logic [MS_W-1:0] ON_END    = MS_W'(ON_MS - 1);
  localparam logic [MS_W-1:0] GAP_END   = MS_W'(GAP_MS - 1);
  localparam logic [MS_W-1:0] PAUSE_END = MS_W'(PAUSE_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_PLAY_ON, S_PLAY_GAP, S_WAIT_IN, S_HOLD, S_PAUSE, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [15:0]             r_div;
  logic [15:0]             r_tpm;
  logic [15:0]             r_lfsr;
  logic [MS_W-1:0]         r_ms;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_level;
  logic [IDX_W-1:0]        r_idx;
  logic [MAX_LEN-1:0][1:0] r_pattern;
  logic [3:0]              r_btn_prev;
  logic                    r_win;
  logic                    r_lose;

  logic [15:0] w_tpm_in;
  logic        w_ms_tick;
  logic        w_state_chg;
  logic [1:0]  w_step;
  logic [3:0]  w_step_oh;
  logic        w_more;
  logic        w_press;
  logic        w_clear;
  logic        w_add;
  logic        w_idx_inc;
  logic        w_idx_clr;
  logic        w_set_level;
  logic        w_set_win;
  logic        w_set_lose;
  logic [3:0]  w_led;
  logic        w_sound;
  logic [1:0]  w_tone;
  logic        w_busy;

  assign w_tpm_in    = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
  assign w_ms_tick   = (r_div == (r_tpm - 16'd1));
  assign w_state_chg = (w_state_nx != r_state);
  assign w_step      = r_pattern[r_idx];
  assign w_step_oh   = 4'b0001 << w_step;
  assign w_more      = (LEN_W'(r_idx) + LEN_W'(1)) < r_len;
  assign w_press     = (btn != 4'd0) && (r_btn_prev == 4'd0);

  always_comb begin
    w_state_nx  = r_state;
    w_clear     = 1'b0;
    w_add       = 1'b0;
    w_idx_inc   = 1'b0;
    w_idx_clr   = 1'b0;
    w_set_level = 1'b0;
    w_set_win   = 1'b0;
    w_set_lose  = 1'b0;
    w_led       = 4'd0;
    w_sound     = 1'b0;
    w_tone      = 2'd0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_busy = 1'b0;
        if (start) begin
          w_clear    = 1'b1;
          w_state_nx = S_ADD;
        end
      end
      S_ADD: begin
        w_add      = 1'b1;
        w_idx_clr  = 1'b1;
        w_state_nx = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        w_led   = w_step_oh;
        w_sound = 1'b1;
        w_tone  = w_step;
        if (w_ms_tick && (r_ms == ON_END)) w_state_nx = S_PLAY_GAP;
      end
      S_PLAY_GAP: begin
        if (w_ms_tick && (r_ms == GAP_END)) begin
          if (w_more) begin
            w_idx_inc  = 1'b1;
            w_state_nx = S_PLAY_ON;
          end else begin
            w_idx_clr  = 1'b1;
            w_state_nx = S_WAIT_IN;
          end
        end
      end
      S_WAIT_IN: begin
        // Only a fresh 0->nonzero edge counts; buttons held from before entry are ignored.
        if (w_press) begin
          if (btn == w_step_oh) begin
            w_state_nx = S_HOLD;
          end else begin
            w_set_lose = 1'b1;
            w_state_nx = S_DONE;
          end
        end
`ifdef SIMON_SEQ_TIMEOUT_EN
        else if (w_ms_tick && (r_ms == MS_W'(TIMEOUT_MS - 1))) begin
          w_set_lose = 1'b1;
          w_state_nx = S_DONE;
        end
`endif
      end
      S_HOLD: begin
        w_led   = btn;
        w_sound = 1'b1;
        w_tone  = w_step;
        if (btn == 4'd0) begin
          if (w_more) begin
            w_idx_inc  = 1'b1;
            w_state_nx = S_WAIT_IN;
          end else begin
            w_set_level = 1'b1;
            w_state_nx  = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (w_ms_tick && (r_ms == PAUSE_END)) begin
          if (r_len < LEN_W'(MAX_LEN)) begin
            w_state_nx = S_ADD;
          end else begin
            w_set_win  = 1'b1;
            w_state_nx = S_DONE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // The divisor is latched only when the divider restarts, so a mid-game change never splits a ms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= 16'd0;
      r_ms  <= '0;
      r_tpm <= 16'd1;
    end else if (w_state_chg) begin
      r_div <= 16'd0;
      r_ms  <= '0;
      r_tpm <= w_tpm_in;
    end else if (w_ms_tick) begin
      r_div <= 16'd0;
      r_ms  <= r_ms + MS_W'(1);
      r_tpm <= w_tpm_in;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr     <= 16'hACE1;
      r_btn_prev <= 4'd0;
      r_pattern  <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_level    <= '0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      r_lfsr     <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      r_btn_prev <= btn;
      if (w_clear) begin
        r_len   <= '0;
        r_level <= '0;
        r_win   <= 1'b0;
        r_lose  <= 1'b0;
      end
      if (w_add) begin
        r_pattern[r_len[IDX_W-1:0]] <= r_lfsr[1:0];
        r_len                       <= r_len + LEN_W'(1);
      end
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + IDX_W'(1);
      if (w_set_level) r_level <= r_len;
      if (w_set_win)   r_win   <= 1'b1;
      if (w_set_lose)  r_lose  <= 1'b1;
    end
  end

  assign led      = w_led;
  assign sound_en = w_sound;
  assign tone     = w_tone;
  assign busy     = w_busy;
  assign level    = r_level;
  assign win      = r_win;
  assign lose     = r_lose;

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - Scoreboard bench for simon_sequencer (default build and MAX_LEN=2 build).
module tb_simon_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tpm;
  logic        drv_start;
  logic [3:0]  drv_btn;
  logic        sel;

  logic        start_a, start_b;
  logic [3:0]  btn_a, btn_b;
  logic [3:0]  led_a, led_b, led_o;
  logic        sound_a, sound_b, sound_o;
  logic [1:0]  tone_a, tone_b, tone_o;
  logic [5:0]  level_a, level_b, level_o;
  logic        busy_a, busy_b, busy_o;
  logic        win_a, win_b, win_o;
  logic        lose_a, lose_b, lose_o;

  always #5 clk = ~clk;

  assign start_a = !sel && drv_start;
  assign start_b = sel && drv_start;
  assign btn_a   = sel ? 4'd0 : drv_btn;
  assign btn_b   = sel ? drv_btn : 4'd0;
  assign led_o   = sel ? led_b : led_a;
  assign sound_o = sel ? sound_b : sound_a;
  assign tone_o  = sel ? tone_b : tone_a;
  assign level_o = sel ? level_b : level_a;
  assign busy_o  = sel ? busy_b : busy_a;
  assign win_o   = sel ? win_b : win_a;
  assign lose_o  = sel ? lose_b : lose_a;

  simon_sequencer #(.TIMEOUT_MS(5)) dut_a (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm), .start(start_a), .btn(btn_a),
    .led(led_a), .sound_en(sound_a), .tone(tone_a), .level(level_a),
    .busy(busy_a), .win(win_a), .lose(lose_a)
  );

  simon_sequencer #(.MAX_LEN(2)) dut_b (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm), .start(start_b), .btn(btn_b),
    .led(led_b), .sound_en(sound_b), .tone(tone_b), .level(level_b),
    .busy(busy_b), .win(win_b), .lose(lose_b)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  logic [1:0]  m_pat [32];
  int          m_len;
  logic [3:0]  exp_led_q [$];
  logic [1:0]  exp_tone_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [3:0] oh(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  task automatic do_reset(input int t);
    rst = 1'b1; drv_start = 1'b0; drv_btn = 4'd0; tpm = 16'(t);
    @(negedge clk);
    rst = 1'b0;
    m_len = 0;
    exp_led_q.delete();
    exp_tone_q.delete();
  endtask

  task automatic add_step();
    m_pat[m_len] = m_lfsr[1:0];
    m_len++;
  endtask

  task automatic start_game();
    drv_start = 1'b1;
    @(negedge clk);
    drv_start = 1'b0;
    n_tests++;
    if (busy_o !== 1'b1 || led_o !== 4'd0 || level_o !== 6'd0 || win_o !== 1'b0 || lose_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start: busy=%b led=%b level=%0d win=%b lose=%b, required busy=1 led=0 level=0 win=0 lose=0",
               busy_o, led_o, level_o, win_o, lose_o);
    end
    m_len = 0;
    add_step();
  endtask

  task automatic play_round(input int t);
    logic [3:0] e_led;
    logic [1:0] e_tone;
    int bad;
    for (int i = 0; i < m_len; i++) begin
      exp_led_q.push_back(oh(m_pat[i]));
      exp_tone_q.push_back(m_pat[i]);
    end
    for (int i = 0; i < m_len; i++) begin
      e_led  = exp_led_q.pop_front();
      e_tone = exp_tone_q.pop_front();
      bad = 0;
      for (int k = 0; k < 300 * t; k++) begin
        @(negedge clk);
        if (led_o !== e_led || sound_o !== 1'b1 || tone_o !== e_tone || busy_o !== 1'b1) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL play_on step %0d: %0d bad cycles, last led=%b tone=%0d, required led=%b tone=%0d",
                 i, bad, led_o, tone_o, e_led, e_tone);
      end
      bad = 0;
      for (int k = 0; k < 100 * t; k++) begin
        @(negedge clk);
        if (led_o !== 4'd0 || sound_o !== 1'b0 || busy_o !== 1'b1) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL play_gap step %0d: %0d non-dark cycles, last led=%b, required led=0", i, bad, led_o);
      end
    end
  endtask

  task automatic enter_wait();
    @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b1 || led_o !== 4'd0 || sound_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_in: busy=%b led=%b sound=%b, required busy=1 led=0 sound=0", busy_o, led_o, sound_o);
    end
  endtask

  task automatic press_all();
    for (int i = 0; i < m_len; i++) begin
      drv_btn = oh(m_pat[i]);
      @(negedge clk);
      n_tests++;
      if (led_o !== oh(m_pat[i]) || sound_o !== 1'b1 || tone_o !== m_pat[i]) begin
        n_fail++;
        $display("FAIL hold step %0d: led=%b sound=%b tone=%0d, required led=%b sound=1 tone=%0d",
                 i, led_o, sound_o, tone_o, oh(m_pat[i]), m_pat[i]);
      end
      drv_btn = 4'd0;
      @(negedge clk);
    end
    n_tests++;
    if (level_o !== 6'(m_len) || busy_o !== 1'b1 || led_o !== 4'd0 || lose_o !== 1'b0) begin
      n_fail++;
      $display("FAIL level: level=%0d busy=%b led=%b lose=%b, required level=%0d busy=1 led=0 lose=0",
               level_o, busy_o, led_o, lose_o, m_len);
    end
  endtask

  task automatic pause_to_add(input int t);
    int bad;
    bad = 0;
    for (int k = 0; k < 500 * t; k++) begin
      @(negedge clk);
      if (led_o !== 4'd0 || busy_o !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pause: %0d bad cycles, last led=%b busy=%b, required led=0 busy=1", bad, led_o, busy_o);
    end
    add_step();
  endtask

  task automatic test_reset();
    sel = 1'b0; drv_start = 1'b0; drv_btn = 4'd0; tpm = 16'd1; rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({led_o, sound_o, tone_o, level_o, busy_o, win_o, lose_o} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0000",
               {led_o, sound_o, tone_o, level_o, busy_o, win_o, lose_o});
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b0 || led_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b led=%b, required busy=0 led=0", busy_o, led_o);
    end
  endtask

  task automatic test_first_play();
    do_reset(10);
    start_game();
    play_round(10);
    enter_wait();
  endtask

  task automatic test_game();
    do_reset(1);
    start_game();
    play_round(1); enter_wait(); press_all(); pause_to_add(1);
    play_round(1); enter_wait(); press_all(); pause_to_add(1);
    play_round(1);
    drv_btn = oh(m_pat[0]);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (led_o !== 4'd0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL held_on_entry: led=%b busy=%b, required led=0 busy=1", led_o, busy_o);
    end
    drv_btn = 4'd0;
    @(negedge clk);
    press_all();
    pause_to_add(1);
    play_round(1);
    enter_wait();
    drv_btn = 4'b0011;
    @(negedge clk);
    drv_btn = 4'd0;
    n_tests++;
    if (lose_o !== 1'b1 || busy_o !== 1'b0 || led_o !== 4'd0 || sound_o !== 1'b0 || level_o !== 6'd3) begin
      n_fail++;
      $display("FAIL two_buttons: lose=%b busy=%b led=%b level=%0d, required lose=1 busy=0 led=0 level=3",
               lose_o, busy_o, led_o, level_o);
    end
  endtask

  task automatic test_wrong_button();
    logic [1:0] w;
    start_game();
    play_round(1);
    enter_wait();
    w = m_pat[0] + 2'd1;
    drv_btn = oh(w);
    @(negedge clk);
    drv_btn = 4'd0;
    n_tests++;
    if (lose_o !== 1'b1 || busy_o !== 1'b0 || led_o !== 4'd0 || level_o !== 6'd0) begin
      n_fail++;
      $display("FAIL wrong_button: lose=%b busy=%b led=%b level=%0d, required lose=1 busy=0 led=0 level=0",
               lose_o, busy_o, led_o, level_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    start_game();
    repeat (50) @(negedge clk);
    n_tests++;
    if (led_o !== oh(m_pat[0])) begin
      n_fail++;
      $display("FAIL mid_play_led: led=%b, required %b", led_o, oh(m_pat[0]));
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({led_o, sound_o, tone_o, level_o, busy_o, win_o, lose_o} !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset_play: got %h, required 0000",
               {led_o, sound_o, tone_o, level_o, busy_o, win_o, lose_o});
    end
    @(negedge clk);
    rst = 1'b0;
    start_game();
    play_round(1);
    enter_wait();
    drv_btn = oh(m_pat[0]);
    @(negedge clk);
    n_tests++;
    if (led_o !== oh(m_pat[0]) || sound_o !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_before_reset: led=%b sound=%b, required led=%b sound=1", led_o, sound_o, oh(m_pat[0]));
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({led_o, sound_o, tone_o, level_o, busy_o, win_o, lose_o} !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset_hold: got %h, required 0000",
               {led_o, sound_o, tone_o, level_o, busy_o, win_o, lose_o});
    end
    @(negedge clk);
    drv_btn = 4'd0;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b0 || led_o !== 4'd0 || level_o !== 6'd0) begin
      n_fail++;
      $display("FAIL after_reset_idle: busy=%b led=%b level=%0d, required 0 0 0", busy_o, led_o, level_o);
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset(1);
    start_game();
    play_round(1);
    enter_wait();
`ifdef SIMON_SEQ_TIMEOUT_EN
    repeat (4) @(negedge clk);
    n_tests++;
    if (lose_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: lose=%b busy=%b, required lose=0 busy=1", lose_o, busy_o);
    end
    @(negedge clk);
    n_tests++;
    if (lose_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: lose=%b busy=%b, required lose=1 busy=0", lose_o, busy_o);
    end
`else
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (busy_o !== 1'b1 || lose_o !== 1'b0 || led_o !== 4'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_timeout: %0d changed cycles, last busy=%b lose=%b, required busy=1 lose=0",
               bad, busy_o, lose_o);
    end
`endif
  endtask

  task automatic test_win();
    do_reset(1);
    sel = 1'b1;
    start_game();
    play_round(1); enter_wait(); press_all(); pause_to_add(1);
    play_round(1); enter_wait(); press_all();
    repeat (499) @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b1 || win_o !== 1'b0) begin
      n_fail++;
      $display("FAIL win_early: busy=%b win=%b, required busy=1 win=0", busy_o, win_o);
    end
    @(negedge clk);
    n_tests++;
    if (win_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 6'd2 || lose_o !== 1'b0 || led_o !== 4'd0) begin
      n_fail++;
      $display("FAIL win: win=%b busy=%b level=%0d lose=%b led=%b, required win=1 busy=0 level=2 lose=0 led=0",
               win_o, busy_o, level_o, lose_o, led_o);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_play();
    test_game();
    test_wrong_button();
    test_reset_mid();
    test_timeout();
    test_win();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
